clas_word_seq: RTL and testbench
================================

Name: clas_word_seq

Overview:
- Multi-cycle sequencer that performs a wide add/subtract one 8-bit slice per cycle, using an external clas_8bit-style add/sub datapath.
- Sits directly upstream of the 8-bit carry-lookahead add/sub stage:
  - drives that stage's a, b, sel and c_in;
  - consumes its result and c_out;
  - chains the carry between slices through a register.
- Gives the team wide arithmetic (default 32-bit) without widening the CLA tree.

Parameters:
- WORDS, 4: number of 8-bit slices; operand width W = 8*WORDS. Legal range 2..16.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand request valid.
- in_ready  output  1  sequencer can accept a request.
- in_sel  input  1  0 = add, 1 = subtract (a - b).
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- slice_a  output  8  to datapath a.
- slice_b  output  8  to datapath b, uninverted; the datapath inverts b when sel=1.
- slice_sel  output  1  to datapath sel.
- slice_c_in  output  1  to datapath c_in.
- slice_result  input  8  from datapath result; combinational, same cycle.
- slice_c_out  input  1  from datapath c_out; same cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  W  full-width sum or difference.
- c_out  output  1  final carry; for subtract, 1 = no borrow.
- zero  output  1  result == 0.

Behaviour:
- States: IDLE, RUN, DONE. Reset (rst=1 at a clock edge, any state) forces:
  - state IDLE;
  - in_ready=1 (after reset);
  - out_valid=0, result=0, c_out=0, zero=0;
  - slice index=0, carry register=0;
  - all slice_* outputs 0.
- IDLE:
  - in_ready=1.
  - On in_valid=1: capture in_a, in_b, in_sel; carry_reg <= in_sel; idx <= 0; go to RUN.
- RUN:
  - in_ready=0.
  - Combinational outputs:
    - slice_a = a_reg[8*idx+7:8*idx]
    - slice_b = b_reg[8*idx+7:8*idx]
    - slice_sel = sel_reg
    - slice_c_in = carry_reg
  - Each cycle: result[8*idx+7:8*idx] <= slice_result; carry_reg <= slice_c_out; idx <= idx+1.
  - When idx == WORDS-1: go to DONE; c_out <= slice_c_out.
- DONE:
  - out_valid=1; result, c_out and zero are held stable.
  - zero is registered, computed from the full result at the DONE transition.
  - On out_ready=1: go to IDLE; out_valid drops the next cycle.
  - out_ready is ignored outside DONE.
- Timing:
  - Latency from the accept edge to out_valid high is WORDS+1 cycles.
  - Throughput is one operation per WORDS+2 cycles minimum.
  - in_ready=0 in RUN and DONE. A new request is never accepted in the same cycle as a result handoff.
- slice_* outputs are 0 when not in RUN.
- Width rules:
  - result is modulo 2^W.
  - Subtract computes a + ~b + 1 via slice chaining.
  - c_out follows the unsigned carry/no-borrow convention of the datapath.
- Reset mid-RUN discards the operation; no out_valid is produced for it.
- Operand registers are not updated outside the IDLE accept.

Optional Feature:
- Macro CLAS_WORD_SEQ_OVF_EN.
- Defined:
  - Adds an output port ovf (1 bit): signed two's-complement overflow.
  - ovf = (a[W-1] == (b[W-1]^sel)) && (result[W-1] != a[W-1]).
  - Registered at the DONE transition, valid with out_valid, reset to 0.
- Not defined: no ovf port and no related logic. All other behaviour is identical.

Test Plan:
- Add, WORDS=4 (bench models the datapath as 8-bit a + (b^{8{sel}}) + c_in): 0x000000FF + 0x00000001 -> result=0x00000100, c_out=0, zero=0; out_valid exactly 5 cycles after the accept edge.
- Add wrap: 0xFFFFFFFF + 0x00000001 -> result=0x00000000, c_out=1, zero=1.
- Subtract, 0x00000007 - 0x00000005 -> result=0x00000002, c_out=1.
- Subtract, 0x00000005 - 0x00000007 -> result=0xFFFFFFFE, c_out=0.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid, result and c_out stable, in_ready=0 throughout. Then out_ready=1 for 1 cycle -> IDLE, in_ready=1 on the next cycle.
- Reset and overflow:
  - Assert rst during RUN at idx=2 -> next cycle IDLE, out_valid=0, result=0.
  - A following add 0x12345678 + 0x11111111 -> 0x23456789.
  - With CLAS_WORD_SEQ_OVF_EN: 0x7FFFFFFF + 0x00000001 -> result=0x80000000, ovf=1.

Source files
------------

// File: rtl/clas_word_seq.sv
// clas_word_seq: wide add/subtract sequencer that feeds an external 8-bit
// carry-lookahead add/sub stage one slice per cycle, least significant first,
// and chains the carry between slices through a register.
// Optional build macro CLAS_WORD_SEQ_OVF_EN adds a registered signed-overflow
// output (ovf) that is valid alongside out_valid.
//
// state | meaning
// IDLE  | ready for a request; operands captured on in_valid
// RUN   | one slice per cycle through the external datapath
// DONE  | result presented until out_ready
module clas_word_seq #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sel,
    input  logic [8*WORDS-1:0]   in_a,
    input  logic [8*WORDS-1:0]   in_b,
    output logic [7:0]           slice_a,
    output logic [7:0]           slice_b,
    output logic                 slice_sel,
    output logic                 slice_c_in,
    input  logic [7:0]           slice_result,
    input  logic                 slice_c_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORDS-1:0]   result,
    output logic                 c_out,
    output logic                 zero
`ifdef CLAS_WORD_SEQ_OVF_EN
    ,
    output logic                 ovf
`endif
);

    localparam int IDXW = $clog2(WORDS);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [WORDS-1:0][7:0] a_q, a_d;
    logic [WORDS-1:0][7:0] b_q, b_d;
    logic [WORDS-1:0][7:0] res_q, res_d;
    logic                  sel_q, sel_d;
    logic                  carry_q, carry_d;
    logic                  c_out_q, c_out_d;
    logic                  zero_q, zero_d;
    logic [IDXW-1:0]       idx_q, idx_d;
`ifdef CLAS_WORD_SEQ_OVF_EN
    logic                  ovf_q, ovf_d;
`endif

    // Next-state: capture in IDLE, fold one datapath slice per RUN cycle,
    // latch the final flags on the last slice.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        c_out_d = c_out_q;
        zero_d  = zero_q;
        idx_d   = idx_q;
`ifdef CLAS_WORD_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sel_d   = in_sel;
                    // Subtract is a + ~b + 1: the +1 enters as the first carry.
                    carry_d = in_sel;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d[idx_q] = slice_result;
                carry_d      = slice_c_out;
                idx_d        = idx_q + IDXW'(1);
                if (idx_q == IDX_LAST) begin
                    // idx parked at 0 so it never leaves the slice range
                    // when WORDS is not a power of two.
                    idx_d   = '0;
                    c_out_d = slice_c_out;
                    zero_d  = (res_d == '0);
`ifdef CLAS_WORD_SEQ_OVF_EN
                    ovf_d   = (a_q[WORDS-1][7] == (b_q[WORDS-1][7] ^ sel_q)) &&
                              (res_d[WORDS-1][7] != a_q[WORDS-1][7]);
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sel_q   <= 1'b0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            zero_q  <= 1'b0;
            idx_q   <= '0;
`ifdef CLAS_WORD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            c_out_q <= c_out_d;
            zero_q  <= zero_d;
            idx_q   <= idx_d;
`ifdef CLAS_WORD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Datapath drive: current slice only while running, quiet otherwise.
    always_comb begin
        slice_a    = 8'd0;
        slice_b    = 8'd0;
        slice_sel  = 1'b0;
        slice_c_in = 1'b0;
        if (state_q == S_RUN) begin
            slice_a    = a_q[idx_q];
            slice_b    = b_q[idx_q];
            slice_sel  = sel_q;
            slice_c_in = carry_q;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign c_out     = c_out_q;
    assign zero      = zero_q;
`ifdef CLAS_WORD_SEQ_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_clas_word_seq.sv
// Testbench for clas_word_seq: models the external 8-bit add/sub stage and
// checks each wide operation against a whole-word arithmetic reference.
module tb_clas_word_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [7:0]   slice_a;
    logic [7:0]   slice_b;
    logic         slice_sel;
    logic         slice_c_in;
    logic [7:0]   slice_result;
    logic         slice_c_out;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         c_out;
    logic         zero;
`ifdef CLAS_WORD_SEQ_OVF_EN
    logic         ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // External 8-bit add/sub stage: a + (b ^ {8{sel}}) + c_in.
    assign {slice_c_out, slice_result} = {1'b0, slice_a} + {1'b0, (slice_b ^ {8{slice_sel}})} + {8'd0, slice_c_in};

    clas_word_seq #(.WORDS(WORDS)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_a         (in_a),
        .in_b         (in_b),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_sel    (slice_sel),
        .slice_c_in   (slice_c_in),
        .slice_result (slice_result),
        .slice_c_out  (slice_c_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .c_out        (c_out),
        .zero         (zero)
`ifdef CLAS_WORD_SEQ_OVF_EN
        ,
        .ovf          (ovf)
`endif
    );

    // Whole-word reference: {carry, result} of a + b or a + ~b + 1.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
        if (sel) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        return {1'b0, a} + {1'b0, b};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, run, hold in DONE for `hold` cycles, hand off.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel, input int hold);
        logic [W:0] m;
        int cyc;
        m = model(a, b, sel);
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_sel = ~sel;
        chk("in_ready_run", 64'(in_ready), 64'd0);
        chk("first_c_in", 64'(slice_c_in), 64'(sel));
        chk("first_slice_a", 64'(slice_a), 64'(a[7:0]));
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", 64'(cyc), 64'(WORDS + 1));
        chk("result", 64'(result), 64'(m[W-1:0]));
        chk("c_out", 64'(c_out), 64'(m[W]));
        chk("zero", 64'(zero), 64'(m[W-1:0] == '0));
`ifdef CLAS_WORD_SEQ_OVF_EN
        chk("ovf", 64'(ovf), 64'((a[W-1] == (b[W-1] ^ sel)) && (m[W-1] != a[W-1])));
`endif
        chk("slice_a_done", 64'(slice_a), 64'd0);
        // New requests offered while the result waits must be ignored.
        in_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_result", 64'(result), 64'(m[W-1:0]));
            chk("hold_c_out", 64'(c_out), 64'(m[W]));
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("handoff_valid", 64'(out_valid), 64'd0);
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_slices", 64'({slice_a, slice_b, slice_sel, slice_c_in}), 64'd0);

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h0000_0007, 32'h0000_0005, 1'b1, 0);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
        do_op(32'hDEAD_BEEF, 32'h0123_4567, 1'b1, 10);

        // Reset while the third slice is on the datapath.
        in_a = 32'hA1B2_C3D4; in_b = 32'h0102_0304; in_sel = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_slice_a", 64'(slice_a), 64'h00B2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result", 64'(result), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_slice_a", 64'(slice_a), 64'd0);
        repeat (8) @(posedge clk);
        #1;
        chk("mid_rst_no_valid", 64'(out_valid), 64'd0);

        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 0);
        do_op(32'h0000_0000, 32'h0000_0000, 1'b1, 0);

        for (int k = 0; k < 24; k++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
